// File: rtl/hps_hex_bank.sv
// Avalon-MM bank of NUM_DIGITS hex digits driving active-low 7-segment outputs.
// Per-digit blinking is built only when HPS_HEX_BLINK_EN is defined.
module hps_hex_bank #(
   parameter int                  NUM_DIGITS     = 6,
   parameter int                  PERIOD_W       = 24,
   parameter logic [PERIOD_W-1:0] DEFAULT_PERIOD = PERIOD_W'(12_499_999)
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [2:0]              address,
   input  logic                    chipselect,
   input  logic                    write_n,
   input  logic [31:0]             writedata,
   output logic [31:0]             readdata,
   output logic [4*NUM_DIGITS-1:0] out_port,
   output logic [7*NUM_DIGITS-1:0] seg_n
);

   localparam int DW = 4 * NUM_DIGITS;
   localparam int SW = 7 * NUM_DIGITS;

   logic                  wr_en;
   logic [DW-1:0]         data_q;
   logic [NUM_DIGITS-1:0] enable_q;
   logic [NUM_DIGITS-1:0] blank;
   logic [SW-1:0]         seg_q;
   logic                  unused_wd;

   assign wr_en     = chipselect && !write_n;
   assign unused_wd = ^writedata;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      case (nib)
         4'h0: hex_to_seg = 7'h40;
         4'h1: hex_to_seg = 7'h79;
         4'h2: hex_to_seg = 7'h24;
         4'h3: hex_to_seg = 7'h30;
         4'h4: hex_to_seg = 7'h19;
         4'h5: hex_to_seg = 7'h12;
         4'h6: hex_to_seg = 7'h02;
         4'h7: hex_to_seg = 7'h78;
         4'h8: hex_to_seg = 7'h00;
         4'h9: hex_to_seg = 7'h10;
         4'hA: hex_to_seg = 7'h08;
         4'hB: hex_to_seg = 7'h03;
         4'hC: hex_to_seg = 7'h46;
         4'hD: hex_to_seg = 7'h21;
         4'hE: hex_to_seg = 7'h06;
         default: hex_to_seg = 7'h0E;
      endcase
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q   <= '0;
         enable_q <= '1;
      end else if (wr_en) begin
         case (address)
            3'd0: data_q   <= writedata[DW-1:0];
            3'd1: enable_q <= writedata[NUM_DIGITS-1:0];
            3'd5: begin
               // Index values beyond the last digit match no iteration and are dropped.
               for (int i = 0; i < NUM_DIGITS; i++)
                  if (writedata[10:8] == 3'(i)) data_q[4*i +: 4] <= writedata[3:0];
            end
            default: ;
         endcase
      end
   end

`ifdef HPS_HEX_BLINK_EN
   logic [NUM_DIGITS-1:0] blink_q;
   logic [PERIOD_W-1:0]   period_q;
   logic [PERIOD_W-1:0]   count_q;
   logic                  phase_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blink_q  <= '0;
         period_q <= DEFAULT_PERIOD;
         count_q  <= DEFAULT_PERIOD;
         phase_q  <= 1'b0;
      end else begin
         if (wr_en && address == 3'd2) blink_q <= writedata[NUM_DIGITS-1:0];
         // A PERIOD write restarts the countdown but leaves the phase alone.
         if (wr_en && address == 3'd3) begin
            period_q <= writedata[PERIOD_W-1:0];
            count_q  <= writedata[PERIOD_W-1:0];
         end else if (count_q == '0) begin
            count_q <= period_q;
            phase_q <= ~phase_q;
         end else begin
            count_q <= count_q - PERIOD_W'(1);
         end
      end
   end

   assign blank = ~enable_q | (blink_q & {NUM_DIGITS{phase_q}});
`else
   assign blank = ~enable_q;
`endif

   // NOTE: combinational outputs get a default first so no path can infer a latch.
   always_comb begin
      readdata = '0;
      if (chipselect) begin
         case (address)
            3'd0: readdata = 32'(data_q);
            3'd1: readdata = 32'(enable_q);
`ifdef HPS_HEX_BLINK_EN
            3'd2: readdata = 32'(blink_q);
            3'd3: readdata = 32'(period_q);
            3'd4: readdata = 32'({count_q, 7'b0, phase_q});
`endif
            default: readdata = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         seg_q <= '1;
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++)
            seg_q[7*i +: 7] <= blank[i] ? 7'h7F : hex_to_seg(data_q[4*i +: 4]);
      end
   end

   assign seg_n    = seg_q;
   assign out_port = data_q;

endmodule
